vm_program_sequencer: RTL and testbench
=======================================

Name: vm_program_sequencer

Overview:
- Fetches and issues VM program instructions, one at a time, to the combinational instruction decoder.
- Owns the program counter, CBRANCH redirection and the program-iteration loop count.
- Reads instructions from an external program buffer with fixed 1-cycle read latency.
- Presents each instruction on a valid/ready port that feeds decode_top directly; decode_top's cbranch indication comes back into this block in the same cycle.

Parameters:
- PROG_LEN, 256, instructions per program; must be a power of 2 and at least 2.
- PC_W, 8, program counter width, equal to log2(PROG_LEN).
- ITER, 2048, program iterations per run.
- ITER_W, 12, iteration counter width; must satisfy 2^ITER_W > ITER.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- start_i  in  1  start a run; sampled only in IDLE or DONE
- mem_rd_o  out  1  program buffer read strobe
- mem_addr_o  out  PC_W  program buffer read address
- mem_data_i  in  64  instruction word, valid exactly 1 cycle after mem_rd_o
- instr_v_o  out  1  instruction valid toward the decoder
- instr_o  out  64  instruction word (same layout as mem_data_i)
- instr_pc_o  out  PC_W  PC of instr_o
- instr_ready_i  in  1  downstream accept
- issue_cbranch_i  in  1  decoder's cbranch flag for the current instr_o; combinational from instr_o
- br_v_i  in  1  branch resolved (from the execute stage)
- br_taken_i  in  1  branch taken; qualified by br_v_i
- br_target_i  in  PC_W  taken target PC; qualified by br_v_i
- iter_done_o  out  1  one-cycle pulse at the end of each iteration
- iter_ack_i  in  1  loop-finalisation complete; next iteration may start
- iter_cnt_o  out  ITER_W  completed iterations
- busy_o  out  1  high in every state except IDLE and DONE
- prog_done_o  out  1  high in DONE

Behaviour:
- Reset values: state=IDLE, pc=0, iter_cnt=0, instr_o=0, instr_pc_o=0. All strobes and flags (mem_rd_o, instr_v_o, iter_done_o, busy_o, prog_done_o) are 0. Reset mid-run aborts immediately with no drain.
- Issue handshake ("hs") is instr_v_o & instr_ready_i.
- States: IDLE, FETCH, WAIT, ISSUE, BR_WAIT, ITER_WAIT, DONE.
- IDLE: on start_i, set pc=0 and iter_cnt=0, then go to FETCH.
- FETCH: assert mem_rd_o=1 with mem_addr_o=pc for exactly 1 cycle, then go to WAIT.
- WAIT: capture mem_data_i into instr_o and pc into instr_pc_o, then go to ISSUE.
- ISSUE: instr_v_o=1. instr_o and instr_pc_o are held stable until hs; no retraction while valid.
  - hs with issue_cbranch_i=1: go to BR_WAIT.
  - hs, non-branch, pc != PROG_LEN-1: pc=pc+1, go to FETCH.
  - hs, non-branch, pc == PROG_LEN-1: go to end-of-iteration (below).
- Issue latency: the first instruction is valid 2 cycles after leaving IDLE. Steady-state throughput is 1 instruction per 3 cycles with no backpressure.
- BR_WAIT: instr_v_o=0. br_v_i is ignored in every other state. On br_v_i:
  - br_taken_i=1: pc=br_target_i, go to FETCH. Any target is accepted, with no range check. A taken branch on the last instruction does not end the iteration.
  - br_taken_i=0: same as the non-branch hs rules (pc+1, or end-of-iteration when pc == PROG_LEN-1).
- br_v_i may arrive in the cycle immediately after hs. It must never be missed, so the minimum BR_WAIT dwell is 1 cycle.
- End-of-iteration:
  - iter_done_o=1 for 1 cycle; iter_cnt increments in the same edge; pc=0.
  - If the new iter_cnt == ITER, go to DONE; otherwise go to ITER_WAIT.
- ITER_WAIT: on iter_ack_i, go to FETCH. iter_ack_i asserted in the same cycle as iter_done_o is not honoured; it is sampled from the next cycle onward.
- DONE: prog_done_o=1, and iter_cnt_o holds ITER. On start_i, behave as IDLE (restart from pc=0, iter_cnt=0).
- start_i while busy_o=1 is ignored.
- Arithmetic: pc wraps naturally modulo 2^PC_W. iter_cnt never exceeds ITER.

Test Plan:
- Straight run, PROG_LEN=4, ITER=2, instr_ready_i=1, iter_ack_i tied high, no branches: instr_pc_o sequence 0,1,2,3,0,1,2,3; iter_done_o pulses twice; DONE with iter_cnt_o=2; every instr_o equals the buffer word at instr_pc_o.
- Backpressure: instr_ready_i low for 5 cycles while pc=1: instr_v_o stays 1 with instr_o and instr_pc_o stable; no mem_rd_o asserted during the stall; sequence then resumes at pc=2.
- Taken branch: pc=3 flagged cbranch; br_v_i arrives 4 cycles after hs with br_taken_i=1 and br_target_i=1: no mem_rd_o during BR_WAIT; next issue is pc=1 and iteration count is unchanged.
- Not-taken branch on the last instruction: pc=PROG_LEN-1 is cbranch and br_taken_i=0: iter_done_o pulses; the block waits in ITER_WAIT until iter_ack_i, then issues pc=0.
- start_i pulsed while busy_o=1 has no effect. A second start_i in DONE restarts the run with iter_cnt_o=0.
- rst asserted in BR_WAIT: next cycle shows IDLE with all outputs at their reset values; a subsequent start_i issues pc=0.

Source files
------------

// File: rtl/vm_program_sequencer.sv
// Program sequencer: fetches VM instructions from a 1-cycle-latency buffer, issues them
// one at a time on a valid/ready port, and handles CBRANCH redirection and iteration looping.
//
// state     | meaning
// ----------|--------------------------------------------------------------
// IDLE      | waiting for start_i after reset
// FETCH     | read strobe to the program buffer at pc
// WAIT      | buffer data returns; captured into the issue register
// ISSUE     | instruction valid toward the decoder, held until accepted
// BR_WAIT   | cbranch issued; waiting for the execute-stage resolution
// ITER_WAIT | iteration finished; waiting for loop-finalisation ack
// DONE      | all iterations complete; start_i restarts the run
module vm_program_sequencer #(
   parameter int PROG_LEN = 256,
   parameter int PC_W     = 8,
   parameter int ITER     = 2048,
   parameter int ITER_W   = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   output logic              mem_rd_o,
   output logic [PC_W-1:0]   mem_addr_o,
   input  logic [63:0]       mem_data_i,
   output logic              instr_v_o,
   output logic [63:0]       instr_o,
   output logic [PC_W-1:0]   instr_pc_o,
   input  logic              instr_ready_i,
   input  logic              issue_cbranch_i,
   input  logic              br_v_i,
   input  logic              br_taken_i,
   input  logic [PC_W-1:0]   br_target_i,
   output logic              iter_done_o,
   input  logic              iter_ack_i,
   output logic [ITER_W-1:0] iter_cnt_o,
   output logic              busy_o,
   output logic              prog_done_o
);

   localparam logic [PC_W-1:0]   LAST_PC  = PC_W'(PROG_LEN - 1);
   localparam logic [ITER_W-1:0] ITER_END = ITER_W'(ITER);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_ISSUE,
      S_BR_WAIT,
      S_ITER_WAIT,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [ITER_W-1:0]   iter_cnt_q, iter_cnt_d;
   logic [63:0]         instr_q, instr_d;
   logic [PC_W-1:0]     instr_pc_q, instr_pc_d;
   logic                iter_done_q, iter_done_d;
   logic                hs;
   logic                advance;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         pc_q        <= '0;
         iter_cnt_q  <= '0;
         instr_q     <= '0;
         instr_pc_q  <= '0;
         iter_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         iter_cnt_q  <= iter_cnt_d;
         instr_q     <= instr_d;
         instr_pc_q  <= instr_pc_d;
         iter_done_q <= iter_done_d;
      end
   end

   assign hs = instr_v_o & instr_ready_i;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      iter_cnt_d  = iter_cnt_q;
      instr_d     = instr_q;
      instr_pc_d  = instr_pc_q;
      iter_done_d = 1'b0;
      advance     = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               pc_d       = '0;
               iter_cnt_d = '0;
               state_d    = S_FETCH;
            end
         end
         S_FETCH: state_d = S_WAIT;
         S_WAIT: begin
            instr_d    = mem_data_i;
            instr_pc_d = pc_q;
            state_d    = S_ISSUE;
         end
         S_ISSUE: begin
            if (hs) begin
               if (issue_cbranch_i) state_d = S_BR_WAIT;
               else                 advance = 1'b1;
            end
         end
         S_BR_WAIT: begin
            if (br_v_i) begin
               if (br_taken_i) begin
                  pc_d    = br_target_i;
                  state_d = S_FETCH;
               end else begin
                  advance = 1'b1;
               end
            end
         end
         // The ack is ignored while the done pulse is still showing
         S_ITER_WAIT: begin
            if (iter_ack_i && !iter_done_q) state_d = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase

      if (advance) begin
         if (pc_q != LAST_PC) begin
            pc_d    = pc_q + PC_W'(1);
            state_d = S_FETCH;
         end else begin
            pc_d        = '0;
            iter_cnt_d  = iter_cnt_q + ITER_W'(1);
            iter_done_d = 1'b1;
            state_d     = ((iter_cnt_q + ITER_W'(1)) == ITER_END) ? S_DONE : S_ITER_WAIT;
         end
      end
   end

   assign mem_rd_o    = (state_q == S_FETCH);
   assign mem_addr_o  = pc_q;
   assign instr_v_o   = (state_q == S_ISSUE);
   assign instr_o     = instr_q;
   assign instr_pc_o  = instr_pc_q;
   assign iter_done_o = iter_done_q;
   assign iter_cnt_o  = iter_cnt_q;
   assign busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);
   assign prog_done_o = (state_q == S_DONE);

endmodule

// File: tb/tb_vm_program_sequencer.sv
// Bench for vm_program_sequencer: directed and randomized runs on a 4-instruction, 2-iteration
// program, checked against a next-PC / iteration-count reference model.
module tb_vm_program_sequencer;

   localparam int PROG_LEN = 4;
   localparam int PC_W     = 2;
   localparam int ITER     = 2;
   localparam int ITER_W   = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              start_i;
   logic              mem_rd_o;
   logic [PC_W-1:0]   mem_addr_o;
   logic [63:0]       mem_data_i;
   logic              instr_v_o;
   logic [63:0]       instr_o;
   logic [PC_W-1:0]   instr_pc_o;
   logic              instr_ready_i;
   logic              issue_cbranch_i;
   logic              br_v_i;
   logic              br_taken_i;
   logic [PC_W-1:0]   br_target_i;
   logic              iter_done_o;
   logic              iter_ack_i;
   logic [ITER_W-1:0] iter_cnt_o;
   logic              busy_o;
   logic              prog_done_o;

   logic [63:0] mem [PROG_LEN];
   int tests = 0;
   int fails = 0;
   int model_pc;
   int model_iter;

   vm_program_sequencer #(
      .PROG_LEN(PROG_LEN), .PC_W(PC_W), .ITER(ITER), .ITER_W(ITER_W)
   ) dut (
      .clk(clk), .rst(rst), .start_i(start_i),
      .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
      .instr_v_o(instr_v_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
      .instr_ready_i(instr_ready_i), .issue_cbranch_i(issue_cbranch_i),
      .br_v_i(br_v_i), .br_taken_i(br_taken_i), .br_target_i(br_target_i),
      .iter_done_o(iter_done_o), .iter_ack_i(iter_ack_i), .iter_cnt_o(iter_cnt_o),
      .busy_o(busy_o), .prog_done_o(prog_done_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
      end
   endtask

   // One clock; the buffer returns the addressed word one cycle after a read, junk otherwise.
   task automatic tick();
      logic            rd;
      logic [PC_W-1:0] a;
      rd = mem_rd_o;
      a  = mem_addr_o;
      @(posedge clk);
      #1;
      mem_data_i = rd ? mem[a] : {$urandom, $urandom};
   endtask

   task automatic chk_reset_state();
      chk("rst_mem_rd", mem_rd_o, 0);
      chk("rst_instr_v", instr_v_o, 0);
      chk("rst_iter_done", iter_done_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_prog_done", prog_done_o, 0);
      chk("rst_instr", instr_o, 0);
      chk("rst_instr_pc", instr_pc_o, 0);
      chk("rst_iter_cnt", iter_cnt_o, 0);
      chk("rst_pc", mem_addr_o, 0);
   endtask

   task automatic start_run();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      model_pc   = 0;
      model_iter = 0;
      chk("start_busy", busy_o, 1);
      chk("start_prog_done", prog_done_o, 0);
      chk("start_iter_cnt", iter_cnt_o, 0);
      chk("start_rd", mem_rd_o, 1);
      chk("start_addr", mem_addr_o, 0);
   endtask

   // Every issue follows an event that put the block in FETCH: valid must appear 2 cycles later.
   task automatic wait_valid();
      int n = 0;
      while (!instr_v_o && n < 8) begin
         tick();
         n++;
      end
      chk("issue_latency", n, 2);
      chk("issue_pc", instr_pc_o, model_pc);
      chk("issue_word", instr_o, mem[model_pc]);
      chk("issue_iter_cnt", iter_cnt_o, model_iter);
   endtask

   task automatic advance(input int ack_dly);
      if (model_pc != PROG_LEN - 1) begin
         model_pc++;
         chk("next_rd", mem_rd_o, 1);
         chk("next_addr", mem_addr_o, model_pc);
         chk("no_iter_done", iter_done_o, 0);
      end else begin
         model_iter++;
         model_pc = 0;
         chk("iter_done_pulse", iter_done_o, 1);
         chk("iter_cnt", iter_cnt_o, model_iter);
         chk("prog_done_at_end", prog_done_o, model_iter == ITER);
         iter_ack_i = 1'b1;
         tick();
         chk("iter_done_single", iter_done_o, 0);
         if (model_iter == ITER) begin
            iter_ack_i = 1'b0;
            chk("done_flag", prog_done_o, 1);
            chk("done_busy", busy_o, 0);
            chk("done_iter_cnt", iter_cnt_o, ITER);
            chk("done_no_rd", mem_rd_o, 0);
         end else begin
            chk("ack_same_cycle_ignored", mem_rd_o, 0);
            iter_ack_i = 1'b0;
            for (int i = 0; i < ack_dly; i++) begin
               tick();
               chk("iter_wait_hold", mem_rd_o, 0);
            end
            iter_ack_i = 1'b1;
            tick();
            iter_ack_i = 1'b0;
            chk("resume_rd", mem_rd_o, 1);
            chk("resume_addr", mem_addr_o, 0);
         end
      end
   endtask

   task automatic issue_one(input int stall, input bit cb, input int br_dly, input bit taken,
                            input logic [PC_W-1:0] tgt, input int ack_dly);
      logic [63:0]     w;
      logic [PC_W-1:0] p;
      wait_valid();
      w = instr_o;
      p = instr_pc_o;
      instr_ready_i   = 1'b0;
      issue_cbranch_i = cb;
      for (int i = 0; i < stall; i++) begin
         start_i = 1'b1;
         tick();
         chk("stall_valid", instr_v_o, 1);
         chk("stall_word", instr_o, w);
         chk("stall_pc", instr_pc_o, p);
         chk("stall_no_rd", mem_rd_o, 0);
      end
      start_i       = 1'b0;
      instr_ready_i = 1'b1;
      tick();
      instr_ready_i   = 1'b0;
      issue_cbranch_i = 1'b0;
      if (cb) begin
         chk("br_wait_no_valid", instr_v_o, 0);
         chk("br_wait_no_rd", mem_rd_o, 0);
         for (int i = 0; i < br_dly; i++) begin
            start_i     = 1'($urandom_range(0, 1));
            br_taken_i  = 1'($urandom_range(0, 1));
            br_target_i = PC_W'($urandom_range(0, PROG_LEN - 1));
            tick();
            chk("br_wait_hold_rd", mem_rd_o, 0);
            chk("br_wait_hold_v", instr_v_o, 0);
            chk("br_wait_busy", busy_o, 1);
         end
         start_i     = 1'b0;
         br_v_i      = 1'b1;
         br_taken_i  = taken;
         br_target_i = tgt;
         tick();
         br_v_i = 1'b0;
         if (taken) begin
            model_pc = int'(tgt);
            chk("taken_rd", mem_rd_o, 1);
            chk("taken_addr", mem_addr_o, model_pc);
            chk("taken_no_iter_done", iter_done_o, 0);
            chk("taken_iter_cnt", iter_cnt_o, model_iter);
         end else begin
            advance(ack_dly);
         end
      end else begin
         advance(ack_dly);
      end
   endtask

   initial begin
      for (int i = 0; i < PROG_LEN; i++) mem[i] = {$urandom, $urandom};
      rst = 1'b1;
      start_i = 1'b0;
      mem_data_i = '0;
      instr_ready_i = 1'b0;
      issue_cbranch_i = 1'b0;
      br_v_i = 1'b0;
      br_taken_i = 1'b0;
      br_target_i = '0;
      iter_ack_i = 1'b0;
      model_pc = 0;
      model_iter = 0;

      tick();
      tick();
      chk_reset_state();
      rst = 1'b0;
      tick();
      chk("idle_stays", busy_o, 0);

      // Straight run: 0,1,2,3,0,1,2,3 then DONE
      start_run();
      for (int i = 0; i < 2 * PROG_LEN; i++) issue_one(0, 1'b0, 0, 1'b0, '0, 0);
      tick();
      chk("done_holds", prog_done_o, 1);
      chk("done_holds_cnt", iter_cnt_o, ITER);

      // Restart from DONE; backpressure at pc=1, taken branch 3->1, not-taken on last
      start_run();
      issue_one(0, 1'b0, 0, 1'b0, '0, 0);
      issue_one(5, 1'b0, 0, 1'b0, '0, 0);
      issue_one(0, 1'b0, 0, 1'b0, '0, 0);
      issue_one(0, 1'b1, 4, 1'b1, PC_W'(1), 0);
      issue_one(0, 1'b0, 0, 1'b0, '0, 0);
      issue_one(0, 1'b0, 0, 1'b0, '0, 0);
      issue_one(0, 1'b1, 0, 1'b0, '0, 3);

      // Randomized remainder; taken branches stop after a while so the run must finish
      for (int k = 0; k < 200 && model_iter < ITER; k++) begin
         bit cb;
         bit tk;
         cb = ($urandom_range(0, 2) == 0);
         tk = (k < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
         issue_one($urandom_range(0, 3), cb, $urandom_range(0, 3), tk,
                   PC_W'($urandom_range(0, PROG_LEN - 1)), $urandom_range(0, 3));
      end
      chk("random_run_done", prog_done_o, 1);

      // Random full runs
      for (int r = 0; r < 3; r++) begin
         start_run();
         for (int k = 0; k < 200 && model_iter < ITER; k++) begin
            bit cb;
            bit tk;
            cb = ($urandom_range(0, 1) == 0);
            tk = (k < 30) ? 1'($urandom_range(0, 1)) : 1'b0;
            issue_one($urandom_range(0, 2), cb, $urandom_range(0, 2), tk,
                      PC_W'($urandom_range(0, PROG_LEN - 1)), $urandom_range(0, 2));
         end
         chk("random_full_done", prog_done_o, 1);
      end

      // Reset while in BR_WAIT, with a resolution arriving on the same edge
      start_run();
      wait_valid();
      instr_ready_i   = 1'b1;
      issue_cbranch_i = 1'b1;
      tick();
      instr_ready_i   = 1'b0;
      issue_cbranch_i = 1'b0;
      tick();
      rst         = 1'b1;
      br_v_i      = 1'b1;
      br_taken_i  = 1'b1;
      br_target_i = PC_W'(2);
      tick();
      rst    = 1'b0;
      br_v_i = 1'b0;
      chk_reset_state();
      tick();
      chk("post_rst_idle", busy_o, 0);
      start_run();
      issue_one(0, 1'b0, 0, 1'b0, '0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
